// File: rtl/raspi_bus_defs.sv
// rtl/raspi_bus_defs.sv - shared command encodings for the Raspberry Pi bus bridge
package raspi_bus_defs;
    localparam int         CMD_BIT      = 8;
    localparam logic [8:0] CMD_IDLE     = 9'h100;
    localparam logic [8:0] CMD_SEL_BASE = 9'h101;
    localparam int         NODATA_BIT   = 8;
endpackage

// File: rtl/raspi_bus_fifo.sv
// rtl/raspi_bus_fifo.sv - per-channel synchronous RX FIFO, head word shown combinationally
module raspi_bus_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/raspi_bus_bridge.sv
// rtl/raspi_bus_bridge.sv - Pi 9-bit parallel bus to per-channel RX FIFOs and TX byte streams
module raspi_bus_bridge
    import raspi_bus_defs::*;
#(
    parameter int CHANNELS    = 4,
    parameter int WORD_BYTES  = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             raspi_clk,
    input  logic                             raspi_dir,
    input  logic [8:0]                       raspi_dat_i,
    output logic [8:0]                       raspi_dat_o,
    output logic                             raspi_dat_oe,
    output logic [CHANNELS-1:0]              rx_valid,
    output logic [CHANNELS*8*WORD_BYTES-1:0] rx_data,
    input  logic [CHANNELS-1:0]              rx_ready,
    input  logic [CHANNELS-1:0]              tx_valid,
    input  logic [CHANNELS*8-1:0]            tx_data,
    output logic [CHANNELS-1:0]              tx_ready,
    output logic [7:0]                       sel,
    output logic [CHANNELS-1:0]              ovf,
    output logic                             frame_err,
    input  logic                             err_clr
);
    localparam int            WW     = 8 * WORD_BYTES;
    localparam int            CW     = $clog2(WORD_BYTES + 1);
    localparam logic [CW-1:0] LAST   = CW'(WORD_BYTES - 1);
    localparam logic [8:0]    CH_MAX = 9'(CHANNELS);

    logic [SYNC_STAGES-1:0] clk_sr;
    logic [SYNC_STAGES-1:0] dir_sr;
    logic [8:0]             dat_sr [SYNC_STAGES];
    logic                   clk_prev;
    logic                   clk_s, dir_s, stb;
    logic [8:0]             dat_s;

    logic [CW-1:0]       byte_cnt;
    logic [WW-1:0]       asm_word, next_word, push_word;
    logic                push_q;
    logic [7:0]          push_ch;
    logic                wr_stb, rd_stb, is_cmd, sel_ok, is_idle, frame_set;
    logic [7:0]          low;
    logic                cur_valid;
    logic [7:0]          cur_data;
    logic [8:0]          tx_word;
    logic [CHANNELS-1:0] ovf_set, fifo_push, fifo_full, fifo_empty;

    assign clk_s  = clk_sr[SYNC_STAGES-1];
    assign dir_s  = dir_sr[SYNC_STAGES-1];
    assign dat_s  = dat_sr[SYNC_STAGES-1];
    assign stb    = clk_s && !clk_prev;
    assign wr_stb = stb && dir_s;
    assign rd_stb = stb && !dir_s;
    assign is_cmd = dat_s[CMD_BIT];
    assign low    = dat_s[7:0];

    assign is_idle      = (low == CMD_IDLE[7:0]);
    assign sel_ok       = (low >= CMD_SEL_BASE[7:0]) && ({1'b0, low} <= CH_MAX);
    assign raspi_dat_oe = !dir_s && (sel != 8'd0);
    assign rx_valid     = ~fifo_empty;

    always_comb begin
        frame_set = 1'b0;
        if (wr_stb && is_cmd && ((!is_idle && !sel_ok) || byte_cnt != '0)) frame_set = 1'b1;
        if (wr_stb && !is_cmd && sel == 8'd0) frame_set = 1'b1;
        next_word = asm_word;
        for (int b = 0; b < WORD_BYTES; b++)
            if (byte_cnt == CW'(b)) next_word[b*8 +: 8] = low;
        cur_valid = 1'b0;
        cur_data  = 8'd0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == 8'(i + 1)) begin
                cur_valid = tx_valid[i];
                cur_data  = tx_data[i*8 +: 8];
            end
        end
        tx_word             = {1'b0, cur_data};
        tx_word[NODATA_BIT] = !cur_valid;
        for (int i = 0; i < CHANNELS; i++) begin
            fifo_push[i] = push_q && (push_ch == 8'(i));
            ovf_set[i]   = fifo_push[i] && fifo_full[i] && !rx_ready[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sr   <= '0;
            dir_sr   <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) dat_sr[s] <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sr   <= {clk_sr[SYNC_STAGES-2:0], raspi_clk};
            dir_sr   <= {dir_sr[SYNC_STAGES-2:0], raspi_dir};
            dat_sr[0] <= raspi_dat_i;
            for (int s = 1; s < SYNC_STAGES; s++) dat_sr[s] <= dat_sr[s-1];
            clk_prev <= clk_s;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel         <= 8'd0;
            byte_cnt    <= '0;
            asm_word    <= '0;
            push_q      <= 1'b0;
            push_ch     <= 8'd0;
            push_word   <= '0;
            frame_err   <= 1'b0;
            ovf         <= '0;
            tx_ready    <= '0;
            raspi_dat_o <= 9'd0;
        end else begin
            push_q      <= 1'b0;
            tx_ready    <= '0;
            frame_err   <= (frame_err && !err_clr) || frame_set;
            ovf         <= (ovf & ~{CHANNELS{err_clr}}) | ovf_set;
            raspi_dat_o <= (sel != 8'd0) ? tx_word : 9'd0;
            if (wr_stb && is_cmd) begin
                byte_cnt <= '0;
                asm_word <= '0;
                if (is_idle)     sel <= 8'd0;
                else if (sel_ok) sel <= low;
            end else if (wr_stb && sel != 8'd0) begin
                if (byte_cnt == LAST) begin
                    push_q    <= 1'b1;
                    push_ch   <= sel - 8'd1;
                    push_word <= next_word;
                    byte_cnt  <= '0;
                    asm_word  <= '0;
                end else begin
                    asm_word <= next_word;
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
            if (rd_stb && sel != 8'd0 && cur_valid)
                tx_ready <= CHANNELS'(1) << (sel - 8'd1);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_fifo
        raspi_bus_fifo #(.DATA_W(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .resetn  (resetn),
            .push    (fifo_push[g]),
            .wr_data (push_word),
            .pop     (rx_ready[g]),
            .rd_data (rx_data[g*WW +: WW]),
            .full    (fifo_full[g]),
            .empty   (fifo_empty[g])
        );
    end
endmodule

// File: tb/tb_raspi_bus_bridge.sv
// tb/tb_raspi_bus_bridge.sv - self-checking bench for raspi_bus_bridge
module tb_raspi_bus_bridge;
    localparam int CH = 4, WB = 4, DEPTH = 16, SS = 2, WW = 8 * WB;

    logic             clk = 1'b0, resetn = 1'b0;
    logic             raspi_clk = 1'b0, raspi_dir = 1'b1;
    logic [8:0]       raspi_dat_i = 9'd0;
    logic [8:0]       raspi_dat_o;
    logic             raspi_dat_oe;
    logic [CH-1:0]    rx_valid, rx_ready = '0, tx_valid = '0, tx_ready, ovf;
    logic [CH*WW-1:0] rx_data;
    logic [CH*8-1:0]  tx_data = '0;
    logic [7:0]       sel;
    logic             frame_err, err_clr = 1'b0;

    raspi_bus_bridge #(.CHANNELS(CH), .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk(clk), .resetn(resetn), .raspi_clk(raspi_clk), .raspi_dir(raspi_dir),
        .raspi_dat_i(raspi_dat_i), .raspi_dat_o(raspi_dat_o), .raspi_dat_oe(raspi_dat_oe),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .sel(sel), .ovf(ovf),
        .frame_err(frame_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int rdy2_cnt = 0, rdy_other_cnt = 0;
    always @(negedge clk) begin
        rdy2_cnt      <= rdy2_cnt + int'(tx_ready[2]);
        rdy_other_cnt <= rdy_other_cnt + int'(tx_ready[0]) + int'(tx_ready[1]) + int'(tx_ready[3]);
    end

    logic [WW-1:0] mq [CH][$];
    int            m_sel = 0, m_part = 0;
    logic [WW-1:0] m_acc = '0;
    logic          m_ferr = 1'b0;
    logic [CH-1:0] m_ovf = '0;
    int            checks = 0, failures = 0;

    typedef struct { logic [8:0] w; logic [7:0] exp_sel; logic exp_ferr; } vec_t;
    vec_t          vecs [9];
    logic [WW-1:0] sent [DEPTH+1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [8:0] w);
        logic [7:0] b;
        b = w[7:0];
        if (w[8]) begin
            if (m_part != 0) m_ferr = 1'b1;
            m_part = 0;
            m_acc  = '0;
            if (b == 8'd0)           m_sel = 0;
            else if (int'(b) <= CH)  m_sel = int'(b);
            else                     m_ferr = 1'b1;
        end else if (m_sel == 0) begin
            m_ferr = 1'b1;
        end else begin
            m_acc = m_acc | (WW'(b) << (8 * m_part));
            m_part++;
            if (m_part == WB) begin
                if (mq[m_sel-1].size() == DEPTH) m_ovf[m_sel-1] = 1'b1;
                else                             mq[m_sel-1].push_back(m_acc);
                m_part = 0;
                m_acc  = '0;
            end
        end
    endtask

    task automatic strobe();
        repeat (2) @(negedge clk);
        raspi_clk = 1'b1;
        repeat (5) @(negedge clk);
        raspi_clk = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic pi_write(input logic [8:0] w);
        @(negedge clk);
        raspi_dir   = 1'b1;
        raspi_dat_i = w;
        strobe();
        model_write(w);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ferr  = 1'b0;
        m_ovf   = '0;
    endtask

    task automatic pop(input int c);
        @(negedge clk);
        rx_ready[c] = 1'b1;
        @(negedge clk);
        rx_ready[c] = 1'b0;
        if (mq[c].size() != 0) void'(mq[c].pop_front());
        @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        chk({tag, " sel"}, 64'(sel), 64'(m_sel));
        chk({tag, " frame_err"}, 64'(frame_err), 64'(m_ferr));
        chk({tag, " ovf"}, 64'(ovf), 64'(m_ovf));
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("%s rx_valid[%0d]", tag, c), 64'(rx_valid[c]), 64'(mq[c].size() != 0));
            if (mq[c].size() != 0)
                chk($sformatf("%s rx_data[%0d]", tag, c), 64'(rx_data[c*WW +: WW]), 64'(mq[c][0]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset outputs", 64'({rx_valid, sel, ovf, frame_err, raspi_dat_oe, raspi_dat_o, tx_ready}), 64'd0);
        chk("reset rx_data", 64'(|rx_data), 64'd0);
        resetn = 1'b1;
        for (int c = 0; c < CH; c++) mq[c].delete();
        m_sel = 0; m_part = 0; m_acc = '0; m_ferr = 1'b0; m_ovf = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int s0, o0, r, k;
        logic [7:0] low;
        vecs[0] = '{9'h101, 8'd1, 1'b0};
        vecs[1] = '{9'h011, 8'd1, 1'b0};
        vecs[2] = '{9'h022, 8'd1, 1'b0};
        vecs[3] = '{9'h033, 8'd1, 1'b0};
        vecs[4] = '{9'h044, 8'd1, 1'b0};
        vecs[5] = '{9'h100, 8'd0, 1'b0};
        vecs[6] = '{9'h103, 8'd3, 1'b0};
        vecs[7] = '{9'h1FF, 8'd3, 1'b1};
        vecs[8] = '{9'h100, 8'd0, 1'b1};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            pi_write(vecs[i].w);
            chk($sformatf("vec%0d sel", i), 64'(sel), 64'(vecs[i].exp_sel));
            chk($sformatf("vec%0d frame_err", i), 64'(frame_err), 64'(vecs[i].exp_ferr));
        end
        chk("word0 rx_valid", 64'(rx_valid[0]), 64'd1);
        chk("word0 rx_data", 64'(rx_data[WW-1:0]), 64'h44332211);
        chk("word0 ovf", 64'(ovf), 64'd0);
        check_state("table");
        pulse_err_clr();

        pi_write(9'h102);
        pi_write(9'h0AA);
        pi_write(9'h0BB);
        pi_write(9'h100);
        chk("partial frame_err", 64'(frame_err), 64'd1);
        chk("partial rx_valid[1]", 64'(rx_valid[1]), 64'd0);
        pulse_err_clr();
        chk("err_clr frame_err", 64'(frame_err), 64'd0);

        pi_write(9'h102);
        for (int w = 0; w <= DEPTH; w++) begin
            sent[w] = WW'($urandom);
            for (int b = 0; b < WB; b++) pi_write({1'b0, sent[w][8*b +: 8]});
        end
        chk("overflow ovf[1]", 64'(ovf[1]), 64'd1);
        chk("overflow ovf[0]", 64'(ovf[0]), 64'd0);
        check_state("overflow");
        for (int w = 0; w < DEPTH; w++) begin
            chk($sformatf("order word%0d", w), 64'(rx_data[WW +: WW]), 64'(sent[w]));
            pop(1);
        end
        chk("drained rx_valid[1]", 64'(rx_valid[1]), 64'd0);
        pulse_err_clr();

        pi_write(9'h103);
        tx_valid[2]         = 1'b1;
        tx_data[2*8 +: 8]   = 8'hA5;
        raspi_dir           = 1'b0;
        repeat (SS + 3) @(negedge clk);
        chk("read oe", 64'(raspi_dat_oe), 64'd1);
        chk("read dat_o", 64'(raspi_dat_o), 64'h0A5);
        s0 = rdy2_cnt; o0 = rdy_other_cnt;
        strobe();
        chk("read pulse1", 64'(rdy2_cnt - s0), 64'd1);
        strobe();
        chk("read pulse2", 64'(rdy2_cnt - s0), 64'd2);
        chk("read other pulses", 64'(rdy_other_cnt - o0), 64'd0);
        tx_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("nodata dat_o", 64'(raspi_dat_o), 64'h1A5);
        s0 = rdy2_cnt;
        strobe();
        chk("nodata pulse", 64'(rdy2_cnt - s0), 64'd0);
        raspi_dir = 1'b1;
        repeat (SS + 3) @(negedge clk);
        chk("write oe", 64'(raspi_dat_oe), 64'd0);
        check_state("read");

        pi_write(9'h101);
        pi_write(9'h001);
        pi_write(9'h002);
        pi_write(9'h003);
        do_reset();
        pi_write(9'h101);
        pi_write(9'h0DE);
        pi_write(9'h0AD);
        pi_write(9'h0BE);
        pi_write(9'h0EF);
        chk("post-reset rx_data", 64'(rx_data[WW-1:0]), 64'hEFBEADDE);
        check_state("post-reset");

        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 99);
            if (r < 20) begin
                k = $urandom_range(0, 6);
                low = (k <= CH) ? 8'(k) : 8'($urandom_range(CH + 1, 255));
                pi_write({1'b1, low});
            end else if (r < 80) begin
                pi_write({1'b0, 8'($urandom)});
            end else if (r < 92) begin
                pop($urandom_range(0, CH - 1));
            end else begin
                pulse_err_clr();
            end
            check_state($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
